// File: rtl/bounce_event_monitor_if.sv
// Record handshake between bounce_event_monitor and its consumer.
// Master drives the head record; slave returns ready.
interface bounce_event_monitor_if #(
   parameter int CNT_W = 16
);
   logic             rec_valid;
   logic             rec_ready;
   logic [CNT_W-1:0] rec_idx;
   real              rec_apex;

   modport master (
      output rec_valid,
      output rec_idx,
      output rec_apex,
      input  rec_ready
   );

   modport slave (
      input  rec_valid,
      input  rec_idx,
      input  rec_apex,
      output rec_ready
   );
endinterface

// File: rtl/bounce_event_monitor.sv
// Bounce phase tracker with per-rebound apex records queued in a FIFO.
// Define BOUNCE_MON_ASSERT_EN to build in the concurrent assertions.
module bounce_event_monitor #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      smp_valid,
   input  real                       x_in,
   input  real                       v_in,
   input  real                       h_limit,
   bounce_event_monitor_if.master    rec,
   output logic [CNT_W-1:0]          bounce_cnt,
   output logic                      overflow
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      S_INIT,
      S_FALL,
      S_GROUND,
      S_RISE
   } state_t;

   state_t           state;
   state_t           state_nxt;
   real              peak;
   real              peak_nxt;
   real              pk_max;
   logic             cnt_inc;
   logic             push;
   real              push_apex;

   logic [CNT_W-1:0] mem_idx [DEPTH];
   real              mem_apex [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             empty;
   logic             full;
   logic             pop;
   logic             wr_en;

   assign pk_max = (x_in > peak) ? x_in : peak;

   always_comb begin
      state_nxt = state;
      peak_nxt  = peak;
      cnt_inc   = 1'b0;
      push      = 1'b0;
      push_apex = 0.0;
      if (smp_valid) begin
         unique case (state)
            S_INIT: begin
               peak_nxt = x_in;
               if (x_in == 0.0)
                  state_nxt = S_GROUND;
               else if (v_in > 0.0)
                  state_nxt = S_RISE;
               else
                  state_nxt = S_FALL;
            end
            S_FALL: begin
               if (x_in == 0.0) begin
                  state_nxt = S_GROUND;
                  cnt_inc   = 1'b1;
               end
            end
            S_GROUND: begin
               if (x_in > 0.0) begin
                  state_nxt = S_RISE;
                  peak_nxt  = x_in;
               end
            end
            S_RISE: begin
               peak_nxt = pk_max;
               if (x_in == 0.0) begin
                  push      = 1'b1;
                  push_apex = peak;
                  cnt_inc   = 1'b1;
                  state_nxt = S_GROUND;
               end else if (x_in > 0.0 && v_in <= 0.0) begin
                  push      = 1'b1;
                  push_apex = pk_max;
                  state_nxt = S_FALL;
               end
            end
            default: state_nxt = S_INIT;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_INIT;
         peak       <= 0.0;
         bounce_cnt <= '0;
      end else begin
         state <= state_nxt;
         peak  <= peak_nxt;
         if (cnt_inc && bounce_cnt != CNT_MAX)
            bounce_cnt <= bounce_cnt + 1'b1;
      end
   end

   assign empty = (count == '0);
   assign full  = (count == FULL);
   assign pop   = !empty && rec.rec_ready;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign wr_en = push && (!full || pop);

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_idx[wr_ptr]  <= bounce_cnt;
         mem_apex[wr_ptr] <= push_apex;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr_en)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         if (wr_en && !pop)
            count <= count + 1'b1;
         else if (pop && !wr_en)
            count <= count - 1'b1;
         if (push && !wr_en)
            overflow <= 1'b1;
      end
   end

   assign rec.rec_valid = !empty;
   assign rec.rec_idx   = empty ? '0 : mem_idx[rd_ptr];
   assign rec.rec_apex  = empty ? 0.0 : mem_apex[rd_ptr];

`ifdef BOUNCE_MON_ASSERT_EN
   logic [63:0] apex_bits;
   assign apex_bits = $realtobits(rec.rec_apex);

   a_apex: assert property (@(posedge clk) disable iff (!rst_n)
      push |-> push_apex <= h_limit);

   a_nonneg: assert property (@(posedge clk) disable iff (!rst_n)
      rec.rec_valid |-> rec.rec_apex >= 0.0);

   a_stable: assert property (@(posedge clk) disable iff (!rst_n)
      rec.rec_valid && !rec.rec_ready |=>
         rec.rec_valid && $stable(rec.rec_idx) && $stable(apex_bits));

   a_cnt_mono: assert property (@(posedge clk) disable iff (!rst_n)
      1'b1 |=> bounce_cnt >= $past(bounce_cnt));
`else
   logic unused_h_limit;
   assign unused_h_limit = (h_limit != 0.0);
`endif
endmodule
